// File: rtl/led_pattern_seq.sv
// led_pattern_seq: tick-stepped LED pattern engine (blink, bouncing scan, binary count, PWM breathe).
module led_pattern_seq #(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              tick,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              wrap,
    output logic [1:0]        cur_mode
);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(N_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    typedef enum logic [1:0] {M_BLINK, M_SCAN, M_COUNT, M_BREATHE} mode_e;
    mode_e               mode_q, mode_d;
    logic                blink_q, blink_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [N_LEDS-1:0]   cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                bdir_q, bdir_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                wrap_q, wrap_d;
    always_comb begin
        mode_d    = mode_q;
        blink_d   = blink_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        bdir_d    = bdir_q;
        pwm_cnt_d = pwm_cnt_q;
        led_d     = '0;
        wrap_d    = 1'b0;
        if (en) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            if (tick && mode_e'(mode) != mode_q) begin
                // a mode switch only loads step 0 of the new pattern; no advance on this tick
                mode_d = mode_e'(mode);
                case (mode_e'(mode))
                    M_BLINK: blink_d = 1'b0;
                    M_SCAN: begin
                        pos_d = '0;
                        dir_d = 1'b0;
                    end
                    M_COUNT: cnt_d = '0;
                    default: begin
                        duty_d = '0;
                        bdir_d = 1'b0;
                    end
                endcase
            end else if (tick) begin
                case (mode_q)
                    M_BLINK: begin
                        blink_d = ~blink_q;
                        wrap_d  = blink_q;
                    end
                    M_SCAN: begin
                        pos_d  = (!dir_q && pos_q != POS_MAX) ? pos_q + 1'b1 : pos_q - 1'b1;
                        dir_d  = dir_q ? (pos_q != POS_W'(1)) : (pos_q == POS_MAX);
                        wrap_d = dir_q && pos_q == POS_W'(1);
                    end
                    M_COUNT: begin
                        cnt_d  = cnt_q + 1'b1;
                        wrap_d = &cnt_q;
                    end
                    default: begin
                        duty_d = (!bdir_q && duty_q != DUTY_MAX) ? duty_q + 1'b1 : duty_q - 1'b1;
                        bdir_d = bdir_q ? (duty_q != PWM_BITS'(1)) : (duty_q == DUTY_MAX);
                        wrap_d = bdir_q && duty_q == PWM_BITS'(1);
                    end
                endcase
            end
            // led always derives from the (next) pattern state, so it holds between ticks and recovers after en
            case (mode_d)
                M_BLINK:   led_d = {N_LEDS{blink_d}};
                M_SCAN:    led_d = N_LEDS'(1) << pos_d;
                M_COUNT:   led_d = cnt_d;
                default:   led_d = {N_LEDS{pwm_cnt_q < duty_d}};
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= M_BLINK;
            blink_q   <= 1'b0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            duty_q    <= '0;
            bdir_q    <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            blink_q   <= blink_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            bdir_q    <= bdir_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            wrap_q    <= wrap_d;
        end
    end
    assign led      = led_q;
    assign wrap     = wrap_q;
    assign cur_mode = mode_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_led_pattern_seq;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, tick = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] led;
    logic       wrap;
    logic [1:0] cur_mode;
    int checks = 0, failures = 0, tag_n = 0;
    typedef struct {
        bit         cl;
        logic [7:0] led;
        logic       wrap;
        logic [1:0] md;
        int         tag;
    } exp_t;
    exp_t q[$];
    always #5 clk = ~clk;
    led_pattern_seq #(.N_LEDS(8), .PWM_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .mode(mode),
        .led(led), .wrap(wrap), .cur_mode(cur_mode)
    );
    task automatic chk(input string nm, input int tag, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s #%0d actual=%0h required=%0h", nm, tag, a, e);
        end
    endtask
    task automatic cyc(input logic e, input logic t, input logic [1:0] m, input bit cl,
                       input logic [7:0] el, input logic ew, input logic [1:0] em);
        exp_t x;
        @(negedge clk);
        en = e;
        tick = t;
        mode = m;
        x.cl = cl; x.led = el; x.wrap = ew; x.md = em; x.tag = tag_n++;
        q.push_back(x);
    endtask
    task automatic tk(input logic [1:0] m, input logic [7:0] el, input logic ew, input logic [1:0] em);
        cyc(1'b1, 1'b1, m, 1'b1, el, ew, em);
    endtask
    task automatic idle(input int n, input logic [1:0] m, input logic [7:0] el, input logic [1:0] em);
        repeat (n) cyc(1'b1, 1'b0, m, 1'b1, el, 1'b0, em);
    endtask
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.cl) chk("led", x.tag, 32'(led), 32'(x.led));
                chk("wrap", x.tag, 32'(wrap), 32'(x.wrap));
                chk("cur_mode", x.tag, 32'(cur_mode), 32'(x.md));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        int p, on_n, wr_n;
        #2;
        chk("rst_led", 0, 32'(led), 0);
        chk("rst_wrap", 0, 32'(wrap), 0);
        chk("rst_mode", 0, 32'(cur_mode), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tk(2'd0, (i % 2 == 1) ? 8'h00 : 8'hFF, i % 2 == 1, 2'd0);
            idle(3, 2'd0, (i % 2 == 1) ? 8'h00 : 8'hFF, 2'd0);
        end
        tk(2'd0, 8'hFF, 1'b0, 2'd0);
        @(negedge clk);
        tick = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", -1, 32'(led), 0);
        chk("async_rst_mode", -1, 32'(cur_mode), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tk(2'd0, 8'hFF, 1'b0, 2'd0);
        tk(2'd0, 8'h00, 1'b1, 2'd0);
        tk(2'd1, 8'h01, 1'b0, 2'd1);
        for (int k = 0; k < 14; k++) begin
            p = (k < 7) ? k + 1 : 13 - k;
            tk(2'd1, 8'(1 << p), k == 13, 2'd1);
        end
        tk(2'd1, 8'h02, 1'b0, 2'd1);
        tk(2'd1, 8'h04, 1'b0, 2'd1);
        tk(2'd1, 8'h08, 1'b0, 2'd1);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, i % 3 == 1, (i % 2 == 1) ? 2'd2 : 2'd1, 1'b1, 8'h00, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 2'd1, 1'b1, 8'h08, 1'b0, 2'd1);
        tk(2'd1, 8'h10, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 2'd2, 1'b1, 8'h10, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 2'd1, 1'b1, 8'h10, 1'b0, 2'd1);
        tk(2'd1, 8'h20, 1'b0, 2'd1);
        tk(2'd2, 8'h00, 1'b0, 2'd2);
        for (int k = 0; k < 256; k++) tk(2'd2, 8'(k + 1), k == 255, 2'd2);
        tk(2'd3, 8'h00, 1'b0, 2'd3);
        idle(32, 2'd3, 8'h00, 2'd3);
        repeat (4) cyc(1'b1, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 2'd3);
        @(negedge clk);
        tick = 1'b0;
        on_n = 0;
        wr_n = 0;
        repeat (32) begin
            @(posedge clk);
            #1;
            if (led == 8'hFF) on_n++;
            if (wrap) wr_n++;
        end
        chk("pwm_on_clks", -2, 32'(on_n), 8);
        chk("pwm_wraps", -2, 32'(wr_n), 0);
        for (int k = 0; k < 26; k++) cyc(1'b1, 1'b1, 2'd3, 1'b0, 8'h00, k == 25, 2'd3);
        idle(20, 2'd3, 8'h00, 2'd3);
        repeat (3) @(posedge clk);
        #2;
        chk("drain", -3, 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
